// File: rtl/pipe_stim_pkg.sv
// Shared types, LFSR constants and golden function for the pipeline stimulus checker.
package pipe_stim_pkg;

    localparam int unsigned W      = 5;
    localparam int unsigned LFSR_W = 25;

    // Galois right-shift feedback mask for x^25 + x^22 + 1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 25'h1200000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Operand vector; packing order matches the LFSR field mapping (a in the low bits)
    typedef struct packed {
        logic [W-1:0] e;
        logic [W-1:0] d;
        logic [W-1:0] c;
        logic [W-1:0] b;
        logic [W-1:0] a;
    } vec_t;

    // Golden result of the DUT pipeline, modulo 2^W on every step
    function automatic logic [W-1:0] exp_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c, input logic [W-1:0] d,
                                           input logic [W-1:0] e);
        logic [W-1:0] sum_ab;
        logic [W-1:0] sum_cd;
        logic [W-1:0] diff;
        sum_ab = a + b;
        sum_cd = c + d;
        diff   = sum_ab - sum_cd;
        return diff & e;
    endfunction

endpackage

// File: rtl/pipe_stim_if.sv
// Operand/result bus between the stimulus checker (master) and the arithmetic pipeline (slave).
interface pipe_stim_if;
    import pipe_stim_pkg::*;

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic [W-1:0] e;
    logic [W-1:0] s_in;

    modport master (output a, b, c, d, e, input s_in);
    modport slave  (input a, b, c, d, e, output s_in);
endinterface

// File: rtl/pipe_stim_lfsr.sv
// 25-bit maximal-length Galois LFSR; load has priority over advance, a zero seed becomes 1.
module pipe_stim_lfsr
    import pipe_stim_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 25'h0000001
) (
    input  logic              clk,
    input  logic              load,
    input  logic              adv,
    output logic [LFSR_W-1:0] st
);

    localparam logic [LFSR_W-1:0] SEED_FIX = (SEED == '0) ? LFSR_W'(1) : SEED;

    // Reload on load, otherwise step once per advance request
    always_ff @(posedge clk) begin
        if (load) begin
            st <= SEED_FIX;
        end else if (adv) begin
            st <= st[0] ? ((st >> 1) ^ LFSR_TAPS) : (st >> 1);
        end
    end

endmodule

// File: rtl/pipe_stim_checker.sv
// Self-checking driver for the 2-cycle ((a+b)-(c+d))&e pipeline.
// Optional macro PIPE_STIM_FIRST_ERR_EN adds first-mismatch capture outputs.
module pipe_stim_checker
    import pipe_stim_pkg::*;
#(
    parameter int unsigned       LAT  = 2,
    parameter logic [LFSR_W-1:0] SEED = 25'h0000001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         count,
    pipe_stim_if.master        bus,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [7:0]         err_cnt
`ifdef PIPE_STIM_FIRST_ERR_EN
    ,
    output logic [7:0]         first_idx,
    output logic [W-1:0]       first_exp,
    output logic [W-1:0]       first_got
`endif
);

    localparam int unsigned DCW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t            state;
    vec_t              vec_q;
    logic [7:0]        cnt_q;
    logic [7:0]        vec_idx;
    logic [DCW-1:0]    drain_cnt;
    logic [LFSR_W-1:0] lfsr_st;
    logic [LAT-1:0]    dl_vld;
    logic [W-1:0]      dl_exp [LAT];
`ifdef PIPE_STIM_FIRST_ERR_EN
    logic [7:0]        dl_idx [LAT];
    logic              first_seen;
`endif

    logic last_c;
    logic issue_c;
    logic mis_c;

    assign last_c  = (vec_idx == (cnt_q - 8'd1));
    assign issue_c = ((state == IDLE) && start && (count != 8'd0)) ||
                     ((state == ISSUE) && !last_c);
    assign mis_c   = dl_vld[LAT-1] && (bus.s_in != dl_exp[LAT-1]);

    assign bus.a = vec_q.a;
    assign bus.b = vec_q.b;
    assign bus.c = vec_q.c;
    assign bus.d = vec_q.d;
    assign bus.e = vec_q.e;

    pipe_stim_lfsr #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .load (rst),
        .adv  (issue_c),
        .st   (lfsr_st)
    );

    // Golden delay line payload; the valid bits in the control block gate every use
    always_ff @(posedge clk) begin
        dl_exp[0] <= exp_f(vec_q.a, vec_q.b, vec_q.c, vec_q.d, vec_q.e);
        for (int i = 1; i < int'(LAT); i++) begin
            dl_exp[i] <= dl_exp[i-1];
        end
`ifdef PIPE_STIM_FIRST_ERR_EN
        dl_idx[0] <= vec_idx;
        for (int i = 1; i < int'(LAT); i++) begin
            dl_idx[i] <= dl_idx[i-1];
        end
`endif
    end

    // Run FSM, operand register, delay-line valids and result scoring
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vec_q     <= '0;
            cnt_q     <= '0;
            vec_idx   <= '0;
            drain_cnt <= '0;
            dl_vld    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
`ifdef PIPE_STIM_FIRST_ERR_EN
            first_seen <= 1'b0;
            first_idx  <= '0;
            first_exp  <= '0;
            first_got  <= '0;
`endif
        end else begin
            done  <= 1'b0;
            vec_q <= issue_c ? vec_t'(lfsr_st) : '0;

            // Entry pushed behind the vector now on the bus matures when its result arrives
            dl_vld[0] <= (state == ISSUE);
            for (int i = 1; i < int'(LAT); i++) begin
                dl_vld[i] <= dl_vld[i-1];
            end

            if (mis_c && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
`ifdef PIPE_STIM_FIRST_ERR_EN
            if (mis_c && !first_seen) begin
                first_seen <= 1'b1;
                first_idx  <= dl_idx[LAT-1];
                first_exp  <= dl_exp[LAT-1];
                first_got  <= bus.s_in;
            end
`endif

            case (state)
                IDLE: begin
                    if (start) begin
                        err_cnt <= '0;
                        pass    <= 1'b0;
                        vec_idx <= '0;
                        cnt_q   <= count;
`ifdef PIPE_STIM_FIRST_ERR_EN
                        first_seen <= 1'b0;
                        first_idx  <= '0;
                        first_exp  <= '0;
                        first_got  <= '0;
`endif
                        if (count != 8'd0) begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (last_c) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        vec_idx <= vec_idx + 8'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DCW'(LAT - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                DONE: begin
                    pass  <= (err_cnt == 8'd0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stim_checker.sv
// Randomised bench for pipe_stim_checker against a behavioural run model; two instances
// with different seeds share the start/count controls.
module tb_pipe_stim_checker;

    localparam int          LAT   = 2;
    localparam logic [24:0] SEED1 = 25'h1F10483;
    localparam logic [24:0] SEED2 = 25'h1F00400;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] count;
    logic       busy1, done1, pass1, busy2, done2, pass2;
    logic [7:0] err1, err2;
`ifdef PIPE_STIM_FIRST_ERR_EN
    logic [7:0] fidx1, fidx2;
    logic [4:0] fexp1, fgot1, fexp2, fgot2;
`endif

    int n_checks;
    int n_errors;
    int mode;
    logic [24:0] m_st;
    logic [24:0] mv [256];
    bit          mis [256];

    pipe_stim_if bus1 ();
    pipe_stim_if bus2 ();

    pipe_stim_checker #(.LAT(LAT), .SEED(SEED1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .bus(bus1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef PIPE_STIM_FIRST_ERR_EN
        , .first_idx(fidx1), .first_exp(fexp1), .first_got(fgot1)
`endif
    );

    pipe_stim_checker #(.LAT(LAT), .SEED(SEED2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .count(count), .bus(bus2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
`ifdef PIPE_STIM_FIRST_ERR_EN
        , .first_idx(fidx2), .first_exp(fexp2), .first_got(fgot2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] lfsr_next(input logic [24:0] s);
        return s[0] ? ((s >> 1) ^ 25'h1200000) : (s >> 1);
    endfunction

    // Result rule on an {e,d,c,b,a} vector using signed integer arithmetic then mod 32
    function automatic logic [4:0] gold(input logic [24:0] v);
        int sum;
        sum = int'(v[4:0]) + int'(v[9:5]) - int'(v[14:10]) - int'(v[19:15]);
        return 5'(sum) & v[24:20];
    endfunction

    // Stand-in 2-cycle pipelines; mode 1 inverts results, mode 2 flips bit 0 when e is odd
    logic [4:0] p1, p2, q1, q2;
    logic       t1, t2;
    always @(posedge clk) begin
        p1 <= gold({bus1.e, bus1.d, bus1.c, bus1.b, bus1.a});
        t1 <= bus1.e[0];
        p2 <= p1;
        t2 <= t1;
        q1 <= gold({bus2.e, bus2.d, bus2.c, bus2.b, bus2.a});
        q2 <= q1;
    end
    assign bus1.s_in = (mode == 1) ? ~p2 : (mode == 2) ? (p2 ^ {4'b0, t2}) : p2;
    assign bus2.s_in = q2;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, got, want, $time);
        end
    endtask

    // One run of n vectors, checked cycle by cycle from the run's timing rules
    task automatic run(input int n, input int md, input bit poke_busy, input bit poke_done,
                       input bit lit);
        int done_k, errs, errs_tot, first_j;
        mode     = md;
        errs_tot = 0;
        first_j  = -1;
        for (int j = 0; j < n; j++) begin
            mv[j]  = m_st;
            m_st   = lfsr_next(m_st);
            mis[j] = (md == 1) || (md == 2 && mv[j][20]);
            if (mis[j]) begin
                errs_tot++;
                if (first_j < 0) first_j = j;
            end
        end
        done_k = (n == 0) ? 1 : n + LAT + 1;
        @(negedge clk);
        start = 1'b1;
        count = 8'(n);
        for (int k = 1; k <= done_k + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            errs = 0;
            for (int j = 0; j < n; j++) if (mis[j] && (j + LAT + 2 <= k)) errs++;
            check("vec", 32'({bus1.e, bus1.d, bus1.c, bus1.b, bus1.a}),
                  (k <= n) ? 32'(mv[k-1]) : 32'd0);
            check("busy", 32'(busy1), 32'(n > 0 && k <= n + LAT));
            check("done", 32'(done1), 32'(k == done_k));
            check("err_cnt", 32'(err1), 32'(errs));
            check("pass", 32'(pass1), (n == 0 || k == done_k + 1) ? 32'(errs_tot == 0) : 32'd0);
            check("busy2", 32'(busy2), 32'(n > 0 && k <= n + LAT));
            check("done2", 32'(done2), 32'(k == done_k));
            check("err_cnt2", 32'(err2), 32'd0);
            check("pass2", 32'(pass2), (n == 0 || k == done_k + 1) ? 32'd1 : 32'd0);
`ifdef PIPE_STIM_FIRST_ERR_EN
            begin
                bit fire;
                logic [4:0] fe;
                fire = (first_j >= 0) && (k >= first_j + LAT + 2);
                fe   = fire ? gold(mv[first_j]) : 5'd0;
                check("first_idx", 32'(fidx1), fire ? 32'(first_j) : 32'd0);
                check("first_exp", 32'(fexp1), 32'(fe));
                check("first_got", 32'(fgot1),
                      fire ? 32'(fe ^ ((md == 1) ? 5'h1F : 5'h01)) : 32'd0);
                check("first_idx2", 32'(fidx2), 32'd0);
            end
`endif
            if (lit && k == 1) begin
                check("lit_vec1", 32'({bus1.e, bus1.d, bus1.c, bus1.b, bus1.a}),
                      32'({5'd31, 5'd2, 5'd1, 5'd4, 5'd3}));
                check("lit_vec2", 32'({bus2.e, bus2.d, bus2.c, bus2.b, bus2.a}),
                      32'({5'd31, 5'd0, 5'd1, 5'd0, 5'd0}));
            end
            if (lit && k == 3) begin
                check("lit_s1", 32'(bus1.s_in), 32'd4);
                check("lit_s2", 32'(bus2.s_in), 32'd31);
            end
            if (poke_busy && k == 2) begin
                start = 1'b1;
                count = 8'd9;
            end
            if (poke_done && k == done_k) begin
                start = 1'b1;
                count = 8'd3;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mode     = 0;
        rst      = 1'b1;
        start    = 1'b0;
        count    = 8'd0;
        m_st     = SEED1;

        repeat (3) @(negedge clk);
        check("rst_vec", 32'({bus1.e, bus1.d, bus1.c, bus1.b, bus1.a}), 32'd0);
        check("rst_ctl", 32'({busy1, done1, pass1, busy2, done2, pass2}), 32'd0);
        check("rst_err", 32'({err1, err2}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ctl", 32'({busy1, done1, pass1, err1}), 32'd0);

        run(1, 0, 1'b0, 1'b0, 1'b1);
        run(0, 0, 1'b0, 1'b1, 1'b0);
        run(200, 0, 1'b1, 1'b0, 1'b0);
        run(50, 1, 1'b0, 1'b0, 1'b0);
        run(37, 2, 1'b0, 1'b1, 1'b0);
        run(255, 1, 1'b0, 1'b0, 1'b0);

        // Reset while the fifth of twenty vectors is on the bus
        begin
            logic [24:0] s;
            s = m_st;
            for (int j = 0; j < 20; j++) begin
                mv[j] = s;
                s = lfsr_next(s);
            end
            mode = 0;
            @(negedge clk);
            start = 1'b1;
            count = 8'd20;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                start = 1'b0;
                check("mid_vec", 32'({bus1.e, bus1.d, bus1.c, bus1.b, bus1.a}), 32'(mv[k-1]));
                check("mid_busy", 32'(busy1), 32'd1);
                if (k == 5) rst = 1'b1;
            end
            @(negedge clk);
            rst = 1'b0;
            check("rst_mid_vec", 32'({bus1.e, bus1.d, bus1.c, bus1.b, bus1.a}), 32'd0);
            check("rst_mid_ctl", 32'({busy1, done1, pass1, err1}), 32'd0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("rst_no_done", 32'({busy1, done1, busy2, done2}), 32'd0);
            end
            m_st = SEED1;
        end
        run(3, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run(int'($urandom_range(0, 40)), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
